// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one synchronous 32Kx8 ROM between a CPU port
// (single-byte reads) and a video fetcher port (bursts of consecutive bytes).
// One ROM access is issued per cycle. Read data returns a fixed two cycles
// after the issue cycle, registered per port.
module rom_access_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    // CPU port
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    // burst port
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [LEN_W-1:0]  b_len,
    output logic              b_gnt,
    output logic              b_busy,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_done,
    // ROM side
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd_data
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;        // next burst address to issue
    logic [LEN_W-1:0]  rem;        // burst beats still to issue while in BURST
    logic              alt;        // set: next contended slot belongs to the burst
    logic [ADDR_W-1:0] last_addr;  // last issued address, held when idle

    logic              a_issue;
    logic              b_issue;    // any burst beat issued this cycle
    logic              b_first;    // first beat, issued from IDLE
    logic              issue_last; // the burst beat issued now is the final one
    logic [ADDR_W-1:0] issue_addr;

    // return pipeline: stage 1 tags the cycle the ROM presents data
    logic              p1_a;
    logic              p1_b;
    logic              p1_last;

    // slot arbitration: CPU wins in IDLE; in BURST contended slots alternate
    always_comb begin
        a_issue    = 1'b0;
        b_issue    = 1'b0;
        b_first    = 1'b0;
        issue_addr = last_addr;
        if (!rst) begin
            if (state == S_IDLE) begin
                if (a_req) begin
                    a_issue    = 1'b1;
                    issue_addr = a_addr;
                end else if (b_req) begin
                    b_issue    = 1'b1;
                    b_first    = 1'b1;
                    issue_addr = b_addr;
                end
            end else begin
                if (a_req && !alt) begin
                    a_issue    = 1'b1;
                    issue_addr = a_addr;
                end else begin
                    b_issue    = 1'b1;
                    issue_addr = ptr;
                end
            end
        end
        // rem counts beats still owed after the first; the beat that takes it
        // to zero is the last one
        issue_last = b_first ? (b_len == '0) : (rem == LEN_W'(1));
    end

    assign a_gnt    = a_issue;
    assign b_gnt    = b_first;
    assign b_busy   = (state == S_BURST);
    assign rom_addr = rst ? '0 : issue_addr;

    // burst state, address pointer, beat counter and alternation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            rem       <= '0;
            alt       <= 1'b0;
            last_addr <= '0;
        end else begin
            if (a_issue || b_issue)
                last_addr <= issue_addr;

            if (b_first) begin
                ptr <= b_addr + ADDR_W'(1);
                rem <= b_len;
                if (b_len != '0)
                    state <= S_BURST;
            end else if (state == S_BURST && b_issue) begin
                ptr <= ptr + ADDR_W'(1);
                rem <= rem - LEN_W'(1);
                if (issue_last)
                    state <= S_IDLE;
            end

            // toggle on each contended burst slot; any gap in a_req clears it
            if (state == S_BURST && a_req && !(b_issue && issue_last))
                alt <= ~alt;
            else
                alt <= 1'b0;
        end
    end

    // two-stage return: tag in the ROM data cycle, then register data out
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_a     <= 1'b0;
            p1_b     <= 1'b0;
            p1_last  <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            b_done   <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            p1_a     <= a_issue;
            p1_b     <= b_issue;
            p1_last  <= b_issue && issue_last;
            a_rvalid <= p1_a;
            b_rvalid <= p1_b;
            b_done   <= p1_b && p1_last;
            if (p1_a)
                a_rdata <= rom_rd_data;
            if (p1_b)
                b_rdata <= rom_rd_data;
        end
    end

endmodule
